// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: steps one instruction at a time through
// IFETCH/DECODE/EXEC/MEM/WB and drives the ALU stage, RF, PC and data-memory controls.
module multicycle_control (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MEM_Ack,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic [3:0]  ALU_func,
  output logic        ALU_Bin_sel,
  output logic        lui,
  output logic [1:0]  ImmExt,
  output logic        ALUout_LdEn,
  output logic        MEM_Req,
  output logic        MEM_WrEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        Illegal
);

  localparam logic [2:0] S_IFETCH = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  logic [2:0] state_d;
  logic [2:0] state_q;
  logic [5:0] opcode_s;
  logic [5:0] func_s;
  logic       legal_s;
  logic       unused_instr_s;

  assign opcode_s       = Instr[31:26];
  assign func_s         = Instr[5:0];
  assign unused_instr_s = ^Instr[25:6];

  // Opcode/func legality check used in DECODE
  always_comb begin
    legal_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        if (func_s[5:2] == 4'b1100) begin
          legal_s = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE: legal_s = 1'b1;
      default: legal_s = 1'b0;
    endcase
  end

  // Next-state and per-state output decode; everything is forced low while in reset
  always_comb begin
    state_d       = state_q;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    ALU_func      = 4'b0000;
    ALU_Bin_sel   = 1'b0;
    lui           = 1'b0;
    ImmExt        = 2'b00;
    ALUout_LdEn   = 1'b0;
    MEM_Req       = 1'b0;
    MEM_WrEn      = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    Illegal       = 1'b0;
    if (Reset) begin
      case (state_q)
        S_IFETCH: begin
          IR_LdEn = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (legal_s) begin
            state_d = S_EXEC;
          end else begin
            // undefined encodings retire as a nop so the PC still advances
            Illegal = 1'b1;
            PC_LdEn = 1'b1;
            state_d = S_IFETCH;
          end
        end
        S_EXEC: begin
          ALUout_LdEn = 1'b1;
          state_d     = S_WB;
          case (opcode_s)
            OP_RTYPE: ALU_func = func_s[3:0];
            OP_ADDI:  ALU_Bin_sel = 1'b1;
            OP_ANDI, OP_ORI: begin
              ALU_Bin_sel = 1'b1;
              ImmExt      = 2'b01;
              ALU_func    = opcode_s[3:0];
            end
            OP_LUI: begin
              lui    = 1'b1;
              ImmExt = 2'b10;
            end
            OP_LW, OP_SW: begin
              ALU_Bin_sel = 1'b1;
              state_d     = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              ALUout_LdEn = 1'b0;
              ALU_func    = 4'b0001;
              PC_LdEn     = 1'b1;
              PC_sel      = (opcode_s == OP_BEQ) ? Zero : ~Zero;
              state_d     = S_IFETCH;
            end
            default: state_d = S_IFETCH;
          endcase
        end
        S_MEM: begin
          MEM_Req  = 1'b1;
          MEM_WrEn = (opcode_s == OP_SW);
          if (MEM_Ack) begin
            if (opcode_s == OP_SW) begin
              PC_LdEn = 1'b1;
              state_d = S_IFETCH;
            end else begin
              state_d = S_WB;
            end
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = (opcode_s == OP_LW);
          PC_LdEn       = 1'b1;
          state_d       = S_IFETCH;
        end
        default: state_d = S_IFETCH;
      endcase
    end else begin
      state_d = S_IFETCH;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IFETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
